// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding control: tracks EX/MEM/WB destination shadows, drives forwarding mux selects and stall/flush controls.
// Optional HAZARD_PERF_EN adds 32-bit load-use, flush and mem-stall event counters.
module hazard_forward_ctrl #(
  parameter int REG_ADDR_W         = 5,
  parameter int NUM_STAGES_TRACKED = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  id_regwrite,
  input  logic                  id_is_load,
  input  logic                  id_is_store,
  input  logic                  ex_br_taken,
  input  logic                  mem_stall,
  output logic [1:0]            fwd1_sel,
  output logic [1:0]            fwd2_sel,
  output logic                  mem_fwd2_sel,
  output logic                  pc_hold,
  output logic                  ifid_hold,
  output logic                  ifid_flush,
  output logic                  idex_bubble
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           perf_load_use_cnt,
  output logic [31:0]           perf_flush_cnt,
  output logic [31:0]           perf_mem_stall_cnt
`endif
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  is_load;
    logic                  is_store;
    logic [REG_ADDR_W-1:0] rs2;
  } shadow_t;

  // Index 0 = EX, 1 = MEM, 2 = WB.
  shadow_t    sh_q [NUM_STAGES_TRACKED];
  shadow_t    sh_d [NUM_STAGES_TRACKED];
  shadow_t    id_entry;
  logic [1:0] fwd1_q, fwd1_d, fwd2_q, fwd2_d;
  logic       mem_fwd2_q, mem_fwd2_d;
  logic       advance, load_use;

  function automatic logic is_writer(shadow_t s);
    return s.valid && s.regwrite && (s.rd != '0);
  endfunction

  function automatic logic [1:0] fwd_pick(logic used, logic [REG_ADDR_W-1:0] rs,
                                          shadow_t ex, shadow_t mem);
    if (!used || rs == '0)                          return 2'b00;
    if (is_writer(ex) && !ex.is_load && ex.rd == rs) return 2'b01;
    if (is_writer(mem) && mem.rd == rs)              return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    advance  = !mem_stall;
    // A store's data operand fed by a load is handled later by the MEM-stage mux, so it never stalls.
    load_use = id_valid && is_writer(sh_q[0]) && sh_q[0].is_load &&
               ((id_uses_rs1 && sh_q[0].rd == id_rs1) ||
                (id_uses_rs2 && !id_is_store && sh_q[0].rd == id_rs2));

    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst) begin
      pc_hold = 1'b0;
    end else if (mem_stall) begin
      pc_hold   = 1'b1;
      ifid_hold = 1'b1;
    end else if (ex_br_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
    end

    id_entry.valid    = id_valid;
    id_entry.rd       = id_rd;
    id_entry.regwrite = id_regwrite;
    id_entry.is_load  = id_is_load;
    id_entry.is_store = id_is_store;
    id_entry.rs2      = id_rs2;

    sh_d       = sh_q;
    fwd1_d     = fwd1_q;
    fwd2_d     = fwd2_q;
    mem_fwd2_d = mem_fwd2_q;
    if (advance) begin
      for (int i = NUM_STAGES_TRACKED - 1; i > 0; i--) sh_d[i] = sh_q[i-1];
      sh_d[0] = idex_bubble ? shadow_t'('0) : id_entry;
      if (idex_bubble || !id_valid) begin
        fwd1_d = 2'b00;
        fwd2_d = 2'b00;
      end else begin
        fwd1_d = fwd_pick(id_uses_rs1, id_rs1, sh_q[0], sh_q[1]);
        fwd2_d = fwd_pick(id_uses_rs2, id_rs2, sh_q[0], sh_q[1]);
      end
      // Store entering MEM picks up load data that is entering WB alongside it.
      mem_fwd2_d = sh_q[0].valid && sh_q[0].is_store && is_writer(sh_q[1]) &&
                   sh_q[1].is_load && (sh_q[1].rd == sh_q[0].rs2);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q       <= '{default: shadow_t'('0)};
      fwd1_q     <= 2'b00;
      fwd2_q     <= 2'b00;
      mem_fwd2_q <= 1'b0;
    end else begin
      sh_q       <= sh_d;
      fwd1_q     <= fwd1_d;
      fwd2_q     <= fwd2_d;
      mem_fwd2_q <= mem_fwd2_d;
    end
  end

  assign fwd1_sel     = fwd1_q;
  assign fwd2_sel     = fwd2_q;
  assign mem_fwd2_sel = mem_fwd2_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] lu_cnt_q, lu_cnt_d, fl_cnt_q, fl_cnt_d, ms_cnt_q, ms_cnt_d;

  always_comb begin
    lu_cnt_d = lu_cnt_q;
    fl_cnt_d = fl_cnt_q;
    ms_cnt_d = ms_cnt_q;
    if (mem_stall)                           ms_cnt_d = ms_cnt_q + 32'd1;
    if (!mem_stall && ex_br_taken)           fl_cnt_d = fl_cnt_q + 32'd1;
    if (!mem_stall && !ex_br_taken && load_use) lu_cnt_d = lu_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lu_cnt_q <= '0;
      fl_cnt_q <= '0;
      ms_cnt_q <= '0;
    end else begin
      lu_cnt_q <= lu_cnt_d;
      fl_cnt_q <= fl_cnt_d;
      ms_cnt_q <= ms_cnt_d;
    end
  end

  assign perf_load_use_cnt  = lu_cnt_q;
  assign perf_flush_cnt     = fl_cnt_q;
  assign perf_mem_stall_cnt = ms_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed, table-driven bench for hazard_forward_ctrl; each table row is one cycle of ID contents and expected outputs.
module tb_hazard_forward_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid, id_uses_rs1, id_uses_rs2, id_regwrite, id_is_load, id_is_store;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_br_taken, mem_stall;
  logic [1:0] fwd1_sel, fwd2_sel;
  logic       mem_fwd2_sel, pc_hold, ifid_hold, ifid_flush, idex_bubble;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_load_use_cnt, perf_flush_cnt, perf_mem_stall_cnt;
`endif

  hazard_forward_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_regwrite(id_regwrite),
    .id_is_load(id_is_load), .id_is_store(id_is_store), .ex_br_taken(ex_br_taken),
    .mem_stall(mem_stall), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .mem_fwd2_sel(mem_fwd2_sel),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble)
`ifdef HAZARD_PERF_EN
    , .perf_load_use_cnt(perf_load_use_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_mem_stall_cnt(perf_mem_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v; logic [4:0] rs1, rs2, rd; logic u1, u2, rw, ld, st;
  } ins_t;

  typedef struct {
    ins_t i; logic br, ms; logic [1:0] f1, f2; logic mf, ph, fl, bb;
  } vec_t;

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];

  function automatic ins_t nop();
    return '0;
  endfunction

  function automatic ins_t add(int rd, int rs1, int rs2);
    ins_t t = '0;
    t.v = 1; t.rd = rd[4:0]; t.rs1 = rs1[4:0]; t.rs2 = rs2[4:0]; t.u1 = 1; t.u2 = 1; t.rw = 1;
    return t;
  endfunction

  function automatic ins_t lw(int rd, int rs1);
    ins_t t = '0;
    t.v = 1; t.rd = rd[4:0]; t.rs1 = rs1[4:0]; t.u1 = 1; t.rw = 1; t.ld = 1;
    return t;
  endfunction

  function automatic ins_t sw(int rs1, int rs2);
    ins_t t = '0;
    t.v = 1; t.rs1 = rs1[4:0]; t.rs2 = rs2[4:0]; t.u1 = 1; t.u2 = 1; t.st = 1;
    return t;
  endfunction

  function automatic vec_t row(ins_t i, logic br, logic ms, logic [1:0] f1, logic [1:0] f2,
                               logic mf, logic ph, logic fl, logic bb);
    vec_t r;
    r.i = i; r.br = br; r.ms = ms; r.f1 = f1; r.f2 = f2; r.mf = mf; r.ph = ph; r.fl = fl; r.bb = bb;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(ins_t i, logic br, logic ms);
    id_valid = i.v; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd;
    id_uses_rs1 = i.u1; id_uses_rs2 = i.u2; id_regwrite = i.rw;
    id_is_load = i.ld; id_is_store = i.st; ex_br_taken = br; mem_stall = ms;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, ".fwd1"}, 32'(fwd1_sel), 0);
    chk({tag, ".fwd2"}, 32'(fwd2_sel), 0);
    chk({tag, ".memfwd"}, 32'(mem_fwd2_sel), 0);
    chk({tag, ".pc_hold"}, 32'(pc_hold), 0);
    chk({tag, ".ifid_hold"}, 32'(ifid_hold), 0);
    chk({tag, ".flush"}, 32'(ifid_flush), 0);
    chk({tag, ".bubble"}, 32'(idex_bubble), 0);
  endtask

  initial begin
    drive(nop(), 0, 0);
    #12;
    chk_all_zero("reset");
    drive(nop(), 0, 1);
    #1;
    chk("reset_stall.pc_hold", 32'(pc_hold), 0);
    drive(nop(), 0, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Rows: ID contents, br, stall, then expected fwd1, fwd2, mem_fwd2, hold, flush, bubble.
    tbl.push_back(row(nop(),        0, 0, 2'b00, 2'b00, 0, 0, 0, 0)); // 0
    tbl.push_back(row(add(5, 1, 2), 0, 0, 2'b00, 2'b00, 0, 0, 0, 0)); // 1
    tbl.push_back(row(add(6, 5, 1), 0, 0, 2'b00, 2'b00, 0, 0, 0, 0)); // 2
    tbl.push_back(row(nop(),        0, 0, 2'b01, 2'b00, 0, 0, 0, 0)); // 3 EX->EX forward
    tbl.push_back(row(add(5, 1, 2), 0, 0, 2'b00, 2'b00, 0, 0, 0, 0)); // 4
    tbl.push_back(row(nop(),        0, 0, 2'b00, 2'b00, 0, 0, 0, 0)); // 5
    tbl.push_back(row(add(7, 1, 5), 0, 0, 2'b00, 2'b00, 0, 0, 0, 0)); // 6
    tbl.push_back(row(nop(),        0, 0, 2'b00, 2'b10, 0, 0, 0, 0)); // 7 MEM->EX forward
    tbl.push_back(row(add(0, 1, 2), 0, 0, 2'b00, 2'b00, 0, 0, 0, 0)); // 8
    tbl.push_back(row(add(9, 0, 0), 0, 0, 2'b00, 2'b00, 0, 0, 0, 0)); // 9
    tbl.push_back(row(nop(),        0, 0, 2'b00, 2'b00, 0, 0, 0, 0)); // 10 x0 never forwarded
    tbl.push_back(row(lw(8, 2),     0, 0, 2'b00, 2'b00, 0, 0, 0, 0)); // 11
    tbl.push_back(row(add(9, 8, 2), 0, 0, 2'b00, 2'b00, 0, 1, 0, 1)); // 12 load-use
    tbl.push_back(row(add(9, 8, 2), 0, 0, 2'b00, 2'b00, 0, 0, 0, 0)); // 13
    tbl.push_back(row(nop(),        0, 0, 2'b10, 2'b00, 0, 0, 0, 0)); // 14
    tbl.push_back(row(lw(8, 2),     0, 0, 2'b00, 2'b00, 0, 0, 0, 0)); // 15
    tbl.push_back(row(sw(3, 8),     0, 0, 2'b00, 2'b00, 0, 0, 0, 0)); // 16 no stall for store data
    tbl.push_back(row(nop(),        0, 0, 2'b00, 2'b00, 0, 0, 0, 0)); // 17
    tbl.push_back(row(nop(),        0, 0, 2'b00, 2'b00, 1, 0, 0, 0)); // 18 sw in MEM
    tbl.push_back(row(nop(),        0, 0, 2'b00, 2'b00, 0, 0, 0, 0)); // 19
    tbl.push_back(row(lw(8, 2),     0, 0, 2'b00, 2'b00, 0, 0, 0, 0)); // 20
    tbl.push_back(row(add(9, 8, 2), 1, 0, 2'b00, 2'b00, 0, 0, 1, 1)); // 21 flush beats load-use
    tbl.push_back(row(nop(),        0, 0, 2'b00, 2'b00, 0, 0, 0, 0)); // 22
    tbl.push_back(row(lw(8, 2),     0, 0, 2'b00, 2'b00, 0, 0, 0, 0)); // 23
    for (int k = 0; k < 4; k++)
      tbl.push_back(row(add(9, 8, 2), 0, 1, 2'b00, 2'b00, 0, 1, 0, 0)); // 24-27 stall
    tbl.push_back(row(add(9, 8, 2), 0, 0, 2'b00, 2'b00, 0, 1, 0, 1)); // 28 deferred bubble
    tbl.push_back(row(add(9, 8, 2), 0, 0, 2'b00, 2'b00, 0, 0, 0, 0)); // 29
    tbl.push_back(row(nop(),        0, 0, 2'b10, 2'b00, 0, 0, 0, 0)); // 30
    tbl.push_back(row(add(5, 1, 2), 0, 0, 2'b00, 2'b00, 0, 0, 0, 0)); // 31
    tbl.push_back(row(add(6, 5, 1), 0, 0, 2'b00, 2'b00, 0, 0, 0, 0)); // 32
    tbl.push_back(row(nop(),        0, 1, 2'b01, 2'b00, 0, 1, 0, 0)); // 33 select held
    tbl.push_back(row(nop(),        0, 1, 2'b01, 2'b00, 0, 1, 0, 0)); // 34
    tbl.push_back(row(nop(),        0, 0, 2'b01, 2'b00, 0, 0, 0, 0)); // 35
    tbl.push_back(row(nop(),        0, 0, 2'b00, 2'b00, 0, 0, 0, 0)); // 36

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].i, tbl[k].br, tbl[k].ms);
      #2;
      chk($sformatf("row%0d.fwd1", k), 32'(fwd1_sel), 32'(tbl[k].f1));
      chk($sformatf("row%0d.fwd2", k), 32'(fwd2_sel), 32'(tbl[k].f2));
      chk($sformatf("row%0d.memfwd", k), 32'(mem_fwd2_sel), 32'(tbl[k].mf));
      chk($sformatf("row%0d.pc_hold", k), 32'(pc_hold), 32'(tbl[k].ph));
      chk($sformatf("row%0d.ifid_hold", k), 32'(ifid_hold), 32'(tbl[k].ph));
      chk($sformatf("row%0d.flush", k), 32'(ifid_flush), 32'(tbl[k].fl));
      chk($sformatf("row%0d.bubble", k), 32'(idex_bubble), 32'(tbl[k].bb));
      tick();
    end

`ifdef HAZARD_PERF_EN
    chk("perf.load_use", perf_load_use_cnt, 2);
    chk("perf.flush", perf_flush_cnt, 1);
    chk("perf.mem_stall", perf_mem_stall_cnt, 6);
`endif

    // Reset asserted in the middle of a stall with a live forward select.
    drive(add(5, 1, 2), 0, 0);
    tick();
    drive(add(6, 5, 1), 0, 0);
    tick();
    drive(nop(), 0, 1);
    #1;
    chk("pre_reset.fwd1", 32'(fwd1_sel), 1);
    chk("pre_reset.pc_hold", 32'(pc_hold), 1);
    rst = 1'b0;
    #1;
    chk_all_zero("mid_stall_reset");
    tick();
    chk_all_zero("held_reset");
`ifdef HAZARD_PERF_EN
    chk("perf.cleared", perf_mem_stall_cnt, 0);
`endif
    #3;
    rst = 1'b1;
    drive(nop(), 0, 0);
    tick();
    drive(add(6, 5, 1), 0, 0);
    #1;
    chk("cold.no_stale_stall", 32'(pc_hold), 0);
    tick();
    drive(nop(), 0, 0);
    #1;
    chk("cold.no_stale_fwd", 32'(fwd1_sel), 0);
    drive(add(5, 1, 2), 0, 0);
    tick();
    drive(add(6, 5, 1), 0, 0);
    tick();
    drive(nop(), 0, 0);
    #1;
    chk("cold.fwd1", 32'(fwd1_sel), 1);
    chk("cold.fwd2", 32'(fwd2_sel), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end
endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Pipeline control block that produces the select values consumed by the EX-stage forwarding muxes (forwardmux1, forwardmux2) and the MEM-stage store-data mux (mem_forwardmux2).
- Also generates the PC, IF/ID and ID/EX stall/flush controls.
- Keeps its own shadow copy of destination-register info for the EX, MEM and WB stages and advances it in lockstep with the datapath pipeline registers.

Parameters:
- REG_ADDR_W, 5, register index width
- NUM_STAGES_TRACKED, 3, shadow stages (EX, MEM, WB); fixed at 3

Ports:
- clk  in  1  clock
- rst  in  1  reset, active-low
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_rd  in  5  ID destination register
- id_uses_rs1  in  1  instruction reads rs1
- id_uses_rs2  in  1  instruction reads rs2
- id_regwrite  in  1  instruction writes rd
- id_is_load  in  1  lb/lbu/lh/lhu/lw
- id_is_store  in  1  sb/sh/sw
- ex_br_taken  in  1  EX-stage branch/jump redirects PC
- mem_stall  in  1  I- or D-memory not ready; freeze entire pipeline
- fwd1_sel  out  2  forwardmux1 select: 00 idex_rs1, 01 exmem_alu, 10 regfilemux
- fwd2_sel  out  2  forwardmux2 select: 00 idex_rs2, 01 exmem_alu, 10 regfilemux
- mem_fwd2_sel  out  1  mem_forwardmux2 select: 0 exmem_rs2, 1 regfilemux
- pc_hold  out  1  hold PC
- ifid_hold  out  1  hold IF/ID register
- ifid_flush  out  1  squash IF/ID contents
- idex_bubble  out  1  load a NOP into ID/EX

Behaviour:
- Reset:
  - Asynchronous, active-low (rst=0), usable at any time including mid-stall.
  - Clears all shadow stages to invalid and every output to 0.
  - Combinational outputs are forced to 0 while rst=0.
- Shadow stages:
  - Each stage holds {valid, rd, regwrite, is_load, is_store, rs2}.
  - An entry counts as a writer only when valid=1, regwrite=1 and rd!=0.
- Advance occurs on each clk edge with mem_stall=0. On advance: WB<=MEM, MEM<=EX, and EX takes one of:
  - the ID fields, when no bubble and no flush;
  - invalid, when idex_bubble=1.
- mem_stall=1: all shadows and registered selects hold their values; pc_hold=ifid_hold=1; ifid_flush=idex_bubble=0. mem_stall takes priority over every other event.
- Load-use (combinational):
  - Set when EX holds a load writer with rd==id_rs1 and id_uses_rs1; or rd==id_rs2 and id_uses_rs2 and NOT id_is_store.
  - Also requires id_valid=1.
  - Store rs2 fed by a load needs no stall; it is covered by mem_fwd2_sel.
- Control outputs (all with mem_stall=0):
  - load-use → pc_hold=ifid_hold=1 and idex_bubble=1, for exactly one cycle. On the next cycle the load sits in MEM and the condition clears.
  - ex_br_taken → ifid_flush=1 and idex_bubble=1; pc_hold=ifid_hold=0.
  - A branch flush overrides load-use in the same cycle: no hold.
- fwd1_sel/fwd2_sel (registered):
  - Computed on advance for the instruction entering EX, and valid during that instruction's EX cycle.
  - Per source: if the source is used and !=0, EX shadow is a non-load writer and rd matches → 01.
  - Else if the MEM shadow is a writer and rd matches → 10.
  - Else 00.
  - EX takes priority over MEM.
  - A bubble or flushed entry gets 00.
- mem_fwd2_sel (registered):
  - Computed on advance for the instruction entering MEM.
  - 1 iff that instruction is a valid store and the instruction entering WB is a load writer with rd==store rs2.
  - Otherwise 0.
- Latency: selects are valid in the cycle after advance; stall/flush outputs are combinational in the same cycle.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: three additional 32-bit outputs, cleared on reset, each incremented once per qualifying cycle and wrapping at 2^32-1 → 0:
  - perf_load_use_cnt: load-use bubbles
  - perf_flush_cnt: ex_br_taken flushes
  - perf_mem_stall_cnt: mem_stall cycles
- Not defined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- add x5 then add x6,x5,x1 back-to-back → fwd1_sel=01 in the second add's EX cycle; no stall.
- add x5; nop; sub x7,x1,x5 → fwd2_sel=10 in sub's EX cycle; add x5 followed by add x0-dest reader of x0 → sel 00.
- lw x8; add x9,x8,x2 → one cycle with pc_hold=ifid_hold=idex_bubble=1; then fwd1_sel=10 in add's EX cycle.
- lw x8; sw x8,0(x3) → no stall; mem_fwd2_sel=1 in sw's MEM cycle; fwd2_sel=00.
- load-use plus ex_br_taken in the same cycle → ifid_flush=1, idex_bubble=1, pc_hold=0. Separately, mem_stall=1 for 4 cycles during load-use → outputs hold, bubble deferred until mem_stall drops.
- Assert rst=0 mid-stall → all outputs 0 immediately. After release, the first forwarded pair behaves as from cold start.
